// File: rtl/fp_mac_pkg.sv
// Shared definitions for the normalize/round stage: rounding modes, FSM states,
// exception flag bit positions and the default datapath width.
package fp_mac_pkg;

  localparam int unsigned FP_EXP  = 8;
  localparam int unsigned FP_MANT = 23;
  localparam int unsigned FP_STEP = 16;
  localparam int unsigned FP_W    = 3 * FP_MANT + 5;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

endpackage

// File: rtl/round_decide.sv
// Rounding decision: whether to add one ulp, and whether an overflow saturates
// to infinity (otherwise to the largest finite value).
module round_decide
  import fp_mac_pkg::*;
(
  input  logic       sign_i,
  input  logic       lsb_i,
  input  logic       guard_i,
  input  logic       sticky_i,
  input  logic [2:0] rm_i,
  output logic       inc_o,
  output logic       ovf_inf_o
);

  always_comb begin
    inc_o     = 1'b0;
    ovf_inf_o = 1'b0;
    case (rm_i)
      RM_RNE: begin
        inc_o     = guard_i & (sticky_i | lsb_i);
        ovf_inf_o = 1'b1;
      end
      RM_RTZ: begin
        inc_o     = 1'b0;
        ovf_inf_o = 1'b0;
      end
      RM_RDN: begin
        inc_o     = sign_i & (guard_i | sticky_i);
        ovf_inf_o = sign_i;
      end
      RM_RUP: begin
        inc_o     = ~sign_i & (guard_i | sticky_i);
        ovf_inf_o = ~sign_i;
      end
      RM_RMM: begin
        inc_o     = guard_i;
        ovf_inf_o = 1'b1;
      end
      default: begin
        inc_o     = 1'b0;
        ovf_inf_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/normalize_round.sv
// Multi-cycle normalize-and-round stage: shifts the adder magnitude left until the
// leading one reaches the top bit (or the exponent bottoms out), then rounds to IEEE.
module normalize_round
  import fp_mac_pkg::*;
#(
  parameter int unsigned PARM_EXP  = FP_EXP,
  parameter int unsigned PARM_MANT = FP_MANT,
  parameter int unsigned PARM_STEP = FP_STEP
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              Valid_i,
  output logic                              Ready_o,
  input  logic [3*PARM_MANT+4:0]            PosSum_i,
  input  logic                              Sign_i,
  input  logic [PARM_EXP+1:0]               Exp_i,
  input  logic                              Sticky_i,
  input  logic [2:0]                        Rnd_mode_i,
  output logic                              Valid_o,
  input  logic                              Ready_i,
  output logic [PARM_EXP+PARM_MANT:0]       Result_o,
  output logic [4:0]                        Fflags_o
);

  localparam int unsigned W  = 3 * PARM_MANT + 5;
  localparam int unsigned EW = PARM_EXP + 2;
  localparam int unsigned RW = PARM_EXP + PARM_MANT + 1;
  localparam int unsigned SW = PARM_MANT + 2;

  localparam logic signed [EW-1:0] ONE_E   = {{(EW-1){1'b0}}, 1'b1};
  localparam logic signed [EW-1:0] STEP_E  = EW'(PARM_STEP);
  localparam logic signed [EW:0]   ONE_X   = {{EW{1'b0}}, 1'b1};
  localparam logic signed [EW:0]   EXP_MAX = (EW+1)'((1 << PARM_EXP) - 1);

  state_e                state_q, state_d;
  logic [W-1:0]          sum_q, sum_d;
  logic signed [EW-1:0]  exp_q, exp_d;
  logic                  sign_q, sign_d, sticky_q, sticky_d, zero_q, zero_d;
  logic [2:0]            rm_q, rm_d;
  logic [RW-1:0]         result_q, result_d;
  logic [4:0]            fflags_q, fflags_d;
  logic                  valid_q, ready_q;

  logic                  hidden_s, lsb_s, guard_s, sticky_s, inc_s, ovf_inf_s;
  logic [PARM_MANT-1:0]  mant_s, mant_fin_s;
  logic [SW-1:0]         sig_s;
  logic signed [EW:0]    exp_ext_s, exp_fin_s;
  logic                  of_s, nx_s, uf_s;
  logic [RW-1:0]         round_res_s;
  logic [4:0]            round_flags_s;

  assign hidden_s  = sum_q[W-1];
  assign mant_s    = sum_q[W-2 -: PARM_MANT];
  assign lsb_s     = sum_q[W-1-PARM_MANT];
  assign guard_s   = sum_q[W-2-PARM_MANT];
  assign sticky_s  = (|sum_q[W-3-PARM_MANT:0]) | sticky_q;
  assign sig_s     = {1'b0, hidden_s, mant_s} + {{(SW-1){1'b0}}, inc_s};
  assign exp_ext_s = {exp_q[EW-1], exp_q};

  round_decide u_round_decide (
    .sign_i    (sign_q),
    .lsb_i     (lsb_s),
    .guard_i   (guard_s),
    .sticky_i  (sticky_s),
    .rm_i      (rm_q),
    .inc_o     (inc_s),
    .ovf_inf_o (ovf_inf_s)
  );

  // Rounded exponent/mantissa, with carry-out renormalisation and subnormal promotion.
  always_comb begin
    exp_fin_s  = '0;
    mant_fin_s = sig_s[PARM_MANT-1:0];
    if (sig_s[SW-1]) begin
      exp_fin_s  = exp_ext_s + ONE_X;
      mant_fin_s = '0;
    end else if (sig_s[SW-2]) begin
      exp_fin_s  = hidden_s ? exp_ext_s : ONE_X;
    end else begin
      exp_fin_s  = '0;
    end
  end

  assign nx_s = guard_s | sticky_s;
  assign uf_s = nx_s & ~hidden_s;
  assign of_s = (exp_fin_s >= EXP_MAX);

  // Final packed result and flags for the ROUND cycle.
  always_comb begin
    round_res_s   = '0;
    round_flags_s = '0;
    if (zero_q) begin
      round_res_s            = {sign_q, {(RW-1){1'b0}}};
      round_flags_s[FLAG_NX] = sticky_q;
    end else if (of_s) begin
      round_res_s            = ovf_inf_s ? {sign_q, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}}
                                         : {sign_q, {(PARM_EXP-1){1'b1}}, 1'b0, {PARM_MANT{1'b1}}};
      round_flags_s[FLAG_OF] = 1'b1;
      round_flags_s[FLAG_NX] = 1'b1;
    end else begin
      round_res_s            = {sign_q, exp_fin_s[PARM_EXP-1:0], mant_fin_s};
      round_flags_s[FLAG_UF] = uf_s;
      round_flags_s[FLAG_NX] = nx_s;
    end
    round_flags_s[FLAG_NV] = 1'b0;
    round_flags_s[FLAG_DZ] = 1'b0;
  end

  // Next-state logic: operand capture, normalisation shifts, result capture, handshake.
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    sticky_d = sticky_q;
    zero_d   = zero_q;
    rm_d     = rm_q;
    result_d = result_q;
    fflags_d = fflags_q;
    case (state_q)
      ST_IDLE: begin
        if (Valid_i) begin
          sum_d    = PosSum_i;
          exp_d    = Exp_i;
          sign_d   = Sign_i;
          sticky_d = Sticky_i;
          rm_d     = Rnd_mode_i;
          zero_d   = 1'b0;
          state_d  = ST_NORM;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_NORM: begin
        if (sum_q == '0) begin
          zero_d  = 1'b1;
          state_d = ST_ROUND;
        end else if (sum_q[W-1] || (exp_q <= ONE_E)) begin
          state_d = ST_ROUND;
        end else if ((sum_q[W-1 -: PARM_STEP] == '0) && (exp_q > STEP_E)) begin
          sum_d   = sum_q << PARM_STEP;
          exp_d   = exp_q - STEP_E;
        end else begin
          sum_d   = sum_q << 1;
          exp_d   = exp_q - ONE_E;
        end
      end
      ST_ROUND: begin
        result_d = round_res_s;
        fflags_d = round_flags_s;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (Ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; handshake outputs are registered from the next state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      sum_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      sticky_q <= 1'b0;
      zero_q   <= 1'b0;
      rm_q     <= 3'd0;
      result_q <= '0;
      fflags_q <= 5'd0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      sticky_q <= sticky_d;
      zero_q   <= zero_d;
      rm_q     <= rm_d;
      result_q <= result_d;
      fflags_q <= fflags_d;
      valid_q  <= (state_d == ST_DONE);
      ready_q  <= (state_d == ST_IDLE);
    end
  end

  assign Ready_o  = ready_q;
  assign Valid_o  = valid_q;
  assign Result_o = result_q;
  assign Fflags_o = fflags_q;

endmodule

// File: doc/normalize_round.md
NORMALIZE_ROUND -- requirements
Module: normalize_round

Interface
REQ-001 Parameter PARM_EXP, default 8, exponent field width.
REQ-002 Parameter PARM_MANT, default 23, stored mantissa width; W = 3*PARM_MANT+5 denotes the datapath width (74 at defaults).
REQ-003 Parameter PARM_STEP, default 16, coarse left-shift amount per cycle.
REQ-004 clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst_ni  in  1  synchronous, active-low reset.
REQ-006 Valid_i  in  1  upstream operand valid.
REQ-007 Ready_o  out  1  block can accept an operand.
REQ-008 PosSum_i  in  W  positive magnitude from the adder stage.
REQ-009 Sign_i  in  1  result sign.
REQ-010 Exp_i  in  PARM_EXP+2  signed biased exponent of bit W-1 of PosSum_i.
REQ-011 Sticky_i  in  1  sticky bit from the alignment/subtract path.
REQ-012 Rnd_mode_i  in  3  RISC-V rm: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM.
REQ-013 Valid_o  out  1  result valid.
REQ-014 Ready_i  in  1  downstream accepts the result.
REQ-015 Result_o  out  PARM_EXP+PARM_MANT+1  packed IEEE result {sign, exp, mant}.
REQ-016 Fflags_o  out  5  {NV,DZ,OF,UF,NX}; NV and DZ are always 0.

Function
REQ-017 FSM states: IDLE, NORM, ROUND, DONE; Ready_o = 1 only in IDLE; Valid_o = 1 only in DONE.
REQ-018 IDLE: when Valid_i=1, register PosSum_i, Sign_i, Exp_i, Sticky_i and Rnd_mode_i, then go to NORM; otherwise stay in IDLE.
REQ-019 NORM, priority order:
  - sum == 0: go to ROUND, zero path.
  - bit W-1 = 1, or exp <= 1: go to ROUND.
  - top PARM_STEP bits zero and exp > PARM_STEP: shift left by PARM_STEP, exp -= PARM_STEP.
  - otherwise: shift left by 1, exp -= 1.
REQ-020 Shifts fill with zeros; the exponent never drops below 1 during normalization.
REQ-021 ROUND fields:
  - mantissa = bits [W-2 : W-1-PARM_MANT];
  - guard = bit W-2-PARM_MANT;
  - sticky = OR of lower bits | Sticky_i.
REQ-022 Round increment rules:
  - RNE: guard & (sticky | lsb).
  - RTZ: 0.
  - RDN: sign & (guard | sticky).
  - RUP: ~sign & (guard | sticky).
  - RMM: guard.
REQ-023 Increment carry-out past the hidden bit: mantissa becomes 0, exp += 1; a subnormal carrying into the hidden bit becomes exp field 1.
REQ-024 Exp field = 0 if bit W-1 = 0 after NORM (subnormal), else exp.
REQ-025 NX = guard | sticky.
REQ-026 UF = NX & pre-round subnormal.
REQ-027 Overflow when final exp >= 2^PARM_EXP-1; set OF and NX.
REQ-028 Overflow result is infinity for RNE/RMM, RUP with sign 0, and RDN with sign 1; otherwise it is the max finite value.
REQ-029 Zero path: Result_o = {Sign_i, 0...}, Fflags_o = {0,0,0,0,Sticky_i}.
REQ-030 ROUND always goes to DONE after 1 cycle; Result_o and Fflags_o are registered on entry to DONE.
REQ-031 DONE holds Result_o and Fflags_o stable while Ready_i = 0; when Ready_i = 1, go to IDLE (no same-cycle accept).
REQ-032 Latency from the accepting edge to Valid_o high is 2 + (number of NORM shift cycles) edges; worst case is bounded by ceil(W/PARM_STEP) + PARM_STEP + 2.

Reset
REQ-033 When rst_ni = 0 at a rising edge:
  - state becomes IDLE;
  - Valid_o = 0, Ready_o = 1;
  - Result_o = 0, Fflags_o = 0;
  - internal registers are cleared.
REQ-034 Reset in any state, including NORM and DONE, discards the in-flight operation; no Valid_o pulse follows.

Structure
REQ-035 Shared package fp_mac_pkg holds:
  - rounding-mode encodings;
  - the FSM state enum;
  - Fflags bit indices;
  - the W width constant.
REQ-036 One sub-module, round_decide, is combinational: it takes {sign, lsb, guard, sticky, rm} and returns the increment and the overflow-to-infinity select.

Verification
REQ-037 PosSum_i = 1<<73, Exp_i = 127, Sign 0, RNE -> Result_o = 0x3F800000, Fflags_o = 0; Valid_o high 2 edges after accept.
REQ-038 PosSum_i = 1, Exp_i = 200, Sign 1, RNE -> 4 coarse + 9 single shifts; Result_o = 0xBF800000, Fflags_o = 0; Valid_o after 15 edges.
REQ-039 PosSum_i = top 25 bits ones, rest zero, Exp_i = 127, RNE -> Result_o = 0x40000000, Fflags_o = 0x01; with RTZ -> 0x3FFFFFFF, Fflags_o = 0x01.
REQ-040 PosSum_i = 1<<73, Exp_i = 255:
  - RNE -> 0x7F800000, Fflags_o = 0x05;
  - RTZ -> 0x7F7FFFFF, Fflags_o = 0x05.
REQ-041 PosSum_i = 1<<50, Exp_i = 1, Sticky_i = 1 -> subnormal output, Fflags_o = 0x03; PosSum_i = 0, Sign 1 -> Result_o = 0x80000000, Fflags_o = 0.
REQ-042 Hold Ready_i = 0 for 5 cycles in DONE -> Result_o stable and Ready_o = 0 throughout; assert rst_ni = 0 mid-NORM -> next cycle IDLE, Ready_o = 1, no Valid_o pulse.
